axis_frame_arbiter: RTL and testbench

Frame-level round-robin arbiter that shares one AXI-stream sink, typically an `axis_frame_fifo` input, among `PORTS` AXI-stream sources. A grant is held for a whole frame, through the beat with `tlast`, so frames never interleave on the shared sink. Output is fully registered with a skid stage, so `output_axis_tready` never combinationally reaches any `input_axis_tready`.

---
 rtl/axis_frame_arbiter_if.sv | 36 +++
 rtl/axis_frame_arbiter.sv | 138 +++++++++++++
 tb/tb_axis_frame_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_arbiter_if.sv
// Bundles the per-port AXI-stream sources, the shared sink and the grant status.
// The master modport is the arbiter itself; slave is the surrounding environment.
interface axis_frame_arbiter_if #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = (PORTS > 1) ? $clog2(PORTS) : 1
);
    logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata;
    logic [PORTS-1:0]            input_axis_tvalid;
    logic [PORTS-1:0]            input_axis_tready;
    logic [PORTS-1:0]            input_axis_tlast;
    logic [PORTS-1:0]            input_axis_tuser;
    logic [DATA_WIDTH-1:0]       output_axis_tdata;
    logic                        output_axis_tvalid;
    logic                        output_axis_tready;
    logic                        output_axis_tlast;
    logic                        output_axis_tuser;
    logic                        grant_valid;
    logic [IDX_WIDTH-1:0]        grant_index;

    modport master (
        input  input_axis_tdata, input_axis_tvalid, input_axis_tlast, input_axis_tuser,
        input  output_axis_tready,
        output input_axis_tready,
        output output_axis_tdata, output_axis_tvalid, output_axis_tlast, output_axis_tuser,
        output grant_valid, grant_index
    );

    modport slave (
        output input_axis_tdata, input_axis_tvalid, input_axis_tlast, input_axis_tuser,
        output output_axis_tready,
        input  input_axis_tready,
        input  output_axis_tdata, output_axis_tvalid, output_axis_tlast, output_axis_tuser,
        input  grant_valid, grant_index
    );
endinterface

// File: rtl/axis_frame_arbiter.sv
// Frame-level round-robin arbiter sharing one AXI-stream sink among PORTS sources.
// A grant lasts a whole frame; the output is a registered stage backed by a skid register.
module axis_frame_arbiter #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input logic                   clk,
    input logic                   rst,
    axis_frame_arbiter_if.master  bus
);
    typedef enum logic {IDLE, GRANTED} state_t;

    state_t                state;
    logic [IDX_WIDTH-1:0]  grant_idx;
    logic [IDX_WIDTH-1:0]  last_grant;
    logic [IDX_WIDTH-1:0]  scan_idx;
    logic [IDX_WIDTH-1:0]  pick_idx;
    logic                  pick_found;
    logic                  in_ready;

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_user;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_last;
    logic                  skid_user;

    logic                  beat_valid;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  beat_last;
    logic                  beat_user;
    logic                  take;
    logic                  out_free;
    logic                  skid_next;

    // Scan downwards so the port closest after last_grant is the one left standing.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = PORTS; k >= 1; k--) begin
            scan_idx = IDX_WIDTH'((int'(last_grant) + k) % PORTS);
            if (bus.input_axis_tvalid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        beat_valid = 1'b0;
        beat_data  = '0;
        beat_last  = 1'b0;
        beat_user  = 1'b0;
        bus.input_axis_tready = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant_idx == IDX_WIDTH'(i)) begin
                beat_valid = bus.input_axis_tvalid[i];
                beat_data  = bus.input_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                beat_last  = bus.input_axis_tlast[i];
                beat_user  = bus.input_axis_tuser[i];
                bus.input_axis_tready[i] = (state == GRANTED) && in_ready;
            end
        end
    end

    assign take      = (state == GRANTED) && in_ready && beat_valid;
    assign out_free  = !out_valid || bus.output_axis_tready;
    assign skid_next = !out_free && (take || skid_valid);

    // Arbitration FSM and the two-stage output buffer share one register process.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_grant <= IDX_WIDTH'(PORTS - 1);
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_user   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            skid_user  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= GRANTED;
                        grant_idx <= pick_idx;
                    end
                end
                GRANTED: begin
                    if (take && beat_last) begin
                        state      <= IDLE;
                        last_grant <= grant_idx;
                    end
                end
                default: state <= IDLE;
            endcase

            if (out_free) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    out_last   <= skid_last;
                    out_user   <= skid_user;
                    skid_valid <= 1'b0;
                end else if (take) begin
                    out_valid <= 1'b1;
                    out_data  <= beat_data;
                    out_last  <= beat_last;
                    out_user  <= beat_user;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (take) begin
                skid_valid <= 1'b1;
                skid_data  <= beat_data;
                skid_last  <= beat_last;
                skid_user  <= beat_user;
            end

            in_ready <= !skid_next;
        end
    end

    assign bus.output_axis_tvalid = out_valid;
    assign bus.output_axis_tdata  = out_data;
    assign bus.output_axis_tlast  = out_last;
    assign bus.output_axis_tuser  = out_user;
    assign bus.grant_valid        = (state == GRANTED);
    assign bus.grant_index        = grant_idx;
endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Scoreboard bench for axis_frame_arbiter: directed timing checks plus randomized
// frame traffic compared against a frame-level round-robin model.
module tb_axis_frame_arbiter;
    localparam int PORTS = 4;
    localparam int DW    = 8;
    localparam int IW    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axis_frame_arbiter_if #(.PORTS(PORTS), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

    axis_frame_arbiter #(.PORTS(PORTS), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int model_last  = PORTS - 1;

    // Beats are packed as {tuser, tlast, tdata}.
    logic [DW+1:0]    exp_q[$];
    logic [DW+1:0]    port_q[PORTS][$];
    logic [DW+1:0]    mon_exp;
    int               gap[PORTS];
    logic [PORTS-1:0] fired;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int p, input logic v, input logic [DW+1:0] beat);
        bus.input_axis_tvalid[p]         = v;
        bus.input_axis_tdata[p*DW +: DW] = beat[DW-1:0];
        bus.input_axis_tlast[p]          = beat[DW];
        bus.input_axis_tuser[p]          = beat[DW+1];
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output beat is matched against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.output_axis_tvalid === 1'b1 && bus.output_axis_tready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no beat", bus.output_axis_tdata);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_output("out_beat",
                                 {22'b0, bus.output_axis_tuser, bus.output_axis_tlast, bus.output_axis_tdata},
                                 32'(mon_exp));
                end
            end
            if (rst === 1'b0)
                check_output("tready_onehot", 32'($countones(bus.input_axis_tready) > 1), 32'd0);
        end
    end

    // Loads random frames for each port and pushes the expected sink stream, ordered by
    // plain round-robin over the ports that still hold frames.
    task automatic gen_frames(input int nmin, input int nmax, input int lmin, input int lmax);
        logic [DW+1:0] tmp[PORTS][$];
        logic [DW+1:0] b;
        int n, len;
        bit any, found;
        for (int p = 0; p < PORTS; p++) begin
            n = $urandom_range(nmax, nmin);
            for (int f = 0; f < n; f++) begin
                len = $urandom_range(lmax, lmin);
                for (int j = 0; j < len; j++) begin
                    b[DW-1:0] = DW'($urandom);
                    b[DW]     = (j == len - 1);
                    b[DW+1]   = ($urandom_range(3, 0) == 0);
                    port_q[p].push_back(b);
                end
            end
            tmp[p] = port_q[p];
        end
        do begin
            any = 1'b0;
            for (int p = 0; p < PORTS; p++) if (tmp[p].size() > 0) any = 1'b1;
            if (any) begin
                found = 1'b0;
                for (int k = 1; k <= PORTS; k++) begin
                    int p;
                    p = (model_last + k) % PORTS;
                    if (!found && tmp[p].size() > 0) begin
                        found = 1'b1;
                        do begin
                            b = tmp[p].pop_front();
                            exp_q.push_back(b);
                        end while (!b[DW]);
                        model_last = p;
                    end
                end
            end
        end while (any);
    endtask

    // Drives all ports from their queues; pauses only mid-frame so every port with a
    // pending frame is requesting whenever the arbiter is idle.
    task automatic run_frames(input int gap_pct, input int ready_pct, input int budget);
        int  cyc = 0;
        bit  busy;
        logic [DW+1:0] b;
        fired = '0;
        for (int p = 0; p < PORTS; p++) gap[p] = 0;
        busy = 1'b1;
        while (busy && cyc < budget) begin
            next_cycle();
            for (int p = 0; p < PORTS; p++) begin
                if (fired[p]) begin
                    b = port_q[p].pop_front();
                    if (!b[DW] && port_q[p].size() > 0 && $urandom_range(99, 0) < gap_pct)
                        gap[p] = $urandom_range(5, 1);
                end
                if (gap[p] > 0) begin
                    apply_stimulus(p, 1'b0, '0);
                    gap[p]--;
                end else if (port_q[p].size() > 0) begin
                    apply_stimulus(p, 1'b1, port_q[p][0]);
                end else begin
                    apply_stimulus(p, 1'b0, '0);
                end
            end
            bus.output_axis_tready = ($urandom_range(99, 0) < ready_pct);
            @(negedge clk);
            fired = bus.input_axis_tvalid & bus.input_axis_tready;
            cyc++;
            busy = (exp_q.size() > 0);
            for (int p = 0; p < PORTS; p++) if (port_q[p].size() > 0) busy = 1'b1;
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL frame_timeout: got %0d beats outstanding, expected 0", exp_q.size());
            exp_q.delete();
            for (int p = 0; p < PORTS; p++) port_q[p].delete();
        end
        next_cycle();
        for (int p = 0; p < PORTS; p++) apply_stimulus(p, 1'b0, '0);
        bus.output_axis_tready = 1'b1;
        repeat (3) next_cycle();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.input_axis_tvalid  = '0;
        bus.input_axis_tdata   = '0;
        bus.input_axis_tlast   = '0;
        bus.input_axis_tuser   = '0;
        bus.output_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_out_valid", 32'(bus.output_axis_tvalid), 32'd0);
        check_output("rst_out_data", 32'({bus.output_axis_tuser, bus.output_axis_tlast, bus.output_axis_tdata}), 32'd0);
        check_output("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
        check_output("rst_grant_index", 32'(bus.grant_index), 32'd0);
        check_output("rst_tready", 32'(bus.input_axis_tready), 32'd0);

        // Port 2 sends 0x11,0x22,0x33 into an always-ready sink.
        exp_q.push_back({2'b00, 8'h11});
        exp_q.push_back({2'b00, 8'h22});
        exp_q.push_back({2'b01, 8'h33});
        next_cycle();
        apply_stimulus(2, 1'b1, {2'b00, 8'h11});
        @(negedge clk);
        check_output("a_req_grant_valid", 32'(bus.grant_valid), 32'd0);
        check_output("a_req_tready", 32'(bus.input_axis_tready), 32'd0);
        next_cycle();
        @(negedge clk);
        check_output("a_grant_valid", 32'(bus.grant_valid), 32'd1);
        check_output("a_grant_index", 32'(bus.grant_index), 32'd2);
        check_output("a_tready", 32'(bus.input_axis_tready), 32'h4);
        next_cycle();
        apply_stimulus(2, 1'b1, {2'b00, 8'h22});
        @(negedge clk);
        check_output("a_out0", 32'({bus.output_axis_tvalid, bus.output_axis_tdata}), 32'h111);
        next_cycle();
        apply_stimulus(2, 1'b1, {2'b01, 8'h33});
        @(negedge clk);
        check_output("a_out1", 32'({bus.output_axis_tvalid, bus.output_axis_tdata}), 32'h122);
        next_cycle();
        apply_stimulus(2, 1'b0, '0);
        @(negedge clk);
        check_output("a_out2_last", 32'({bus.output_axis_tvalid, bus.output_axis_tlast, bus.output_axis_tdata}), 32'h333);
        check_output("a_end_grant_valid", 32'(bus.grant_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        check_output("a_drained", 32'(bus.output_axis_tvalid), 32'd0);

        // Reset in the middle of a port 2 frame: only the two already-emitted beats appear.
        exp_q.push_back({2'b00, 8'hB0});
        exp_q.push_back({2'b00, 8'hB1});
        next_cycle();
        apply_stimulus(2, 1'b1, {2'b00, 8'hB0});
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        next_cycle();
        apply_stimulus(2, 1'b1, {2'b00, 8'hB1});
        @(negedge clk);
        next_cycle();
        apply_stimulus(2, 1'b1, {2'b00, 8'hB2});
        rst = 1'b1;
        @(negedge clk);
        next_cycle();
        rst = 1'b0;
        apply_stimulus(2, 1'b0, '0);
        @(negedge clk);
        check_output("b_out_valid", 32'(bus.output_axis_tvalid), 32'd0);
        check_output("b_grant_valid", 32'(bus.grant_valid), 32'd0);
        check_output("b_tready", 32'(bus.input_axis_tready), 32'd0);

        // Ports 1 and 3 request together; after reset port 1 must win, then port 3.
        exp_q.push_back({2'b11, 8'hA1});
        exp_q.push_back({2'b01, 8'hA3});
        next_cycle();
        apply_stimulus(1, 1'b1, {2'b11, 8'hA1});
        apply_stimulus(3, 1'b1, {2'b01, 8'hA3});
        @(negedge clk);
        check_output("c_req_grant_valid", 32'(bus.grant_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        check_output("c_grant_first", 32'({bus.grant_valid, bus.grant_index}), 32'h5);
        next_cycle();
        apply_stimulus(1, 1'b0, '0);
        @(negedge clk);
        check_output("c_gap_idle", 32'(bus.grant_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        check_output("c_grant_second", 32'({bus.grant_valid, bus.grant_index}), 32'h7);
        next_cycle();
        apply_stimulus(3, 1'b0, '0);
        repeat (3) next_cycle();
        model_last = 3;

        // All ports offering 2-beat frames into a ready sink.
        gen_frames(3, 3, 2, 2);
        run_frames(0, 100, 2000);

        // Random frames with mid-frame stalls and sink backpressure.
        for (int r = 0; r < 4; r++) begin
            gen_frames(0, 4, 1, 6);
            run_frames(30, 60, 4000);
        end

        // Heavy backpressure so the skid register is exercised constantly.
        gen_frames(1, 3, 3, 8);
        run_frames(0, 35, 6000);

        check_output("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
